// File: rtl/ir_transmitter.sv
// ir_transmitter: NEC-format infrared transmitter.
// Takes a 32-bit code over valid/ready, sends it MSB first as a pulse-distance
// frame (lead mark/space, 32 bit cells, stop mark, idle gap) and gates the mark
// envelope with a carrier to drive the IR LED.
// Optional feature: define IR_TX_REPEAT_EN to send NEC repeat frames while
// repeat_in is held high at the end of each gap.
module ir_transmitter #(
  parameter int UNIT_CYCLES  = 56250,
  parameter int CARRIER_HALF = 1316,
  parameter int GAP_UNITS    = 72
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] code_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic        repeat_in,
  output logic        envelope_out,
  output logic        ir_out,
  output logic        busy_out
);

  localparam int CYC_W     = $clog2(16 * UNIT_CYCLES);
  localparam int MAX_UNITS = (GAP_UNITS > 16) ? GAP_UNITS : 16;
  localparam int UNIT_W    = $clog2(MAX_UNITS);
  localparam int CAR_W     = (CARRIER_HALF > 1) ? $clog2(CARRIER_HALF) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD_MARK,
    S_LEAD_SPACE,
    S_BIT_MARK,
    S_BIT_SPACE,
    S_STOP_MARK,
    S_GAP
`ifdef IR_TX_REPEAT_EN
    , S_REP_SPACE
`endif
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [CYC_W-1:0]    cycle_cnt;
  logic [UNIT_W-1:0]   unit_cnt;
  logic [UNIT_W-1:0]   unit_last;
  logic [4:0]          bit_cnt;
  logic [31:0]         shift_reg;
  logic [CAR_W-1:0]    car_cnt;
  logic                car_phase;
  logic                cycle_last;
  logic                state_done;
  logic                mark_next;
  logic                mark_start;

`ifdef IR_TX_REPEAT_EN
  logic                rep_flag;
`else
  logic                unused_repeat;
  assign unused_repeat = repeat_in;
`endif

  // Last unit index of the current state; a 1 bit stretches its space to 3 units.
  always_comb begin
    unit_last = '0;
    case (state)
      S_LEAD_MARK:  unit_last = UNIT_W'(15);
      S_LEAD_SPACE: unit_last = UNIT_W'(7);
      S_BIT_SPACE:  unit_last = shift_reg[31] ? UNIT_W'(2) : UNIT_W'(0);
      S_GAP:        unit_last = UNIT_W'(GAP_UNITS - 1);
`ifdef IR_TX_REPEAT_EN
      S_REP_SPACE:  unit_last = UNIT_W'(3);
`endif
      default:      unit_last = '0;
    endcase
  end

  assign cycle_last = (cycle_cnt == CYC_W'(UNIT_CYCLES - 1));
  assign state_done = cycle_last && (unit_cnt == unit_last);

  // Frame sequencing: leave a state only when its last unit completes.
  always_comb begin
    next_state = state;
    if (state == S_IDLE) begin
      if (valid_in) next_state = S_LEAD_MARK;
    end else if (state_done) begin
      case (state)
`ifdef IR_TX_REPEAT_EN
        S_LEAD_MARK:  next_state = rep_flag ? S_REP_SPACE : S_LEAD_SPACE;
        S_REP_SPACE:  next_state = S_STOP_MARK;
        S_GAP:        next_state = repeat_in ? S_LEAD_MARK : S_IDLE;
`else
        S_LEAD_MARK:  next_state = S_LEAD_SPACE;
        S_GAP:        next_state = S_IDLE;
`endif
        S_LEAD_SPACE: next_state = S_BIT_MARK;
        S_BIT_MARK:   next_state = S_BIT_SPACE;
        S_BIT_SPACE:  next_state = (bit_cnt == 5'd31) ? S_STOP_MARK : S_BIT_MARK;
        S_STOP_MARK:  next_state = S_GAP;
        default:      next_state = S_IDLE;
      endcase
    end
  end

  assign mark_next  = (next_state == S_LEAD_MARK) || (next_state == S_BIT_MARK) ||
                      (next_state == S_STOP_MARK);
  assign mark_start = mark_next && (next_state != state);

  // State, timing counters, shift register and registered outputs.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state        <= S_IDLE;
      cycle_cnt    <= '0;
      unit_cnt     <= '0;
      bit_cnt      <= '0;
      shift_reg    <= '0;
      car_cnt      <= '0;
      car_phase    <= 1'b0;
      ready_out    <= 1'b1;
      busy_out     <= 1'b0;
      envelope_out <= 1'b0;
      ir_out       <= 1'b0;
`ifdef IR_TX_REPEAT_EN
      rep_flag     <= 1'b0;
`endif
    end else begin
      state        <= next_state;
      ready_out    <= (next_state == S_IDLE);
      busy_out     <= (next_state != S_IDLE);
      envelope_out <= mark_next;

      if ((next_state != state) || (state == S_IDLE)) begin
        cycle_cnt <= '0;
        unit_cnt  <= '0;
      end else if (cycle_last) begin
        cycle_cnt <= '0;
        unit_cnt  <= unit_cnt + 1'b1;
      end else begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end

      if ((state == S_IDLE) && valid_in) begin
        shift_reg <= code_in;
        bit_cnt   <= '0;
`ifdef IR_TX_REPEAT_EN
        rep_flag  <= 1'b0;
`endif
      end else if ((state == S_BIT_SPACE) && state_done) begin
        shift_reg <= {shift_reg[30:0], 1'b0};
        bit_cnt   <= bit_cnt + 1'b1;
      end

`ifdef IR_TX_REPEAT_EN
      if ((state == S_GAP) && (next_state == S_LEAD_MARK)) rep_flag <= 1'b1;
`endif

      if (mark_start) begin
        car_cnt   <= '0;
        car_phase <= 1'b1;
        ir_out    <= 1'b1;
      end else if (mark_next) begin
        if (car_cnt == CAR_W'(CARRIER_HALF - 1)) begin
          car_cnt   <= '0;
          car_phase <= ~car_phase;
          ir_out    <= ~car_phase;
        end else begin
          car_cnt   <= car_cnt + 1'b1;
          ir_out    <= car_phase;
        end
      end else begin
        car_cnt   <= '0;
        car_phase <= 1'b0;
        ir_out    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ir_transmitter.sv
// tb_ir_transmitter: randomized and directed frames compared against a
// behavioural NEC waveform model; also decodes the envelope like a receiver.
// Repeat-frame scenario expectations follow IR_TX_REPEAT_EN.
module tb_ir_transmitter;

  localparam int U   = 10;
  localparam int CH  = 2;
  localparam int GAP = 4;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] code_in;
  logic        valid_in;
  logic        ready_out;
  logic        repeat_in;
  logic        envelope_out;
  logic        ir_out;
  logic        busy_out;

  int errors = 0;
  int checks = 0;

  bit exp_env[$];
  bit exp_ir[$];
  bit cap_env[$];
  int bad_env, bad_ir, bad_rdy;
  int first_env, first_ir, first_rdy;

  ir_transmitter #(.UNIT_CYCLES(U), .CARRIER_HALF(CH), .GAP_UNITS(GAP)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .code_in(code_in),
    .valid_in(valid_in),
    .ready_out(ready_out),
    .repeat_in(repeat_in),
    .envelope_out(envelope_out),
    .ir_out(ir_out),
    .busy_out(busy_out)
  );

  // 10 ns clock
  always #5 clk_in = ~clk_in;

  // Hard stop if anything stalls
  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Append a constant envelope level; marks carry a carrier restarting high
  task automatic add_run(input bit level, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      exp_env.push_back(level);
      exp_ir.push_back(level && (((i / CH) % 2) == 0));
    end
  endtask

  // Expected waveform, cycle by cycle after the handshake edge
  task automatic build_frame(input logic [31:0] code, input int nrep);
    exp_env.delete();
    exp_ir.delete();
    add_run(1'b1, 16 * U);
    add_run(1'b0, 8 * U);
    for (int b = 31; b >= 0; b--) begin
      add_run(1'b1, U);
      add_run(1'b0, code[b] ? 3 * U : U);
    end
    add_run(1'b1, U);
    add_run(1'b0, GAP * U);
    for (int r = 0; r < nrep; r++) begin
      add_run(1'b1, 16 * U);
      add_run(1'b0, 4 * U);
      add_run(1'b1, U);
      add_run(1'b0, GAP * U);
    end
  endtask

  // Receiver-style decode: space after each bit mark longer than 2 units = 1
  function automatic logic [31:0] decode_env();
    int runs[$];
    int len = 1;
    logic [31:0] c = '0;
    for (int k = 1; k < cap_env.size(); k++) begin
      if (cap_env[k] == cap_env[k-1]) len++;
      else begin
        runs.push_back(len);
        len = 1;
      end
    end
    runs.push_back(len);
    for (int b = 0; b < 32; b++)
      if (3 + 2 * b < runs.size()) c = {c[30:0], (runs[3 + 2 * b] > 2 * U)};
    return c;
  endfunction

  // Handshake one code, then record outputs for the modelled frame length
  task automatic drive_frame(input logic [31:0] code, input int pulse_at, input int drop_at);
    int len;
    bit e_env, e_ir, e_rdy;
    len = exp_env.size();
    cap_env.delete();
    bad_env = 0; bad_ir = 0; bad_rdy = 0;
    first_env = -1; first_ir = -1; first_rdy = -1;
    @(negedge clk_in);
    code_in  = code;
    valid_in = 1'b1;
    @(posedge clk_in);
    for (int k = 0; k <= len; k++) begin
      @(negedge clk_in);
      if (k == 0) begin
        valid_in = 1'b0;
        code_in  = $urandom;
      end
      if (k == pulse_at) begin
        valid_in = 1'b1;
        code_in  = 32'h1234_5678;
      end
      if (k == pulse_at + 1) valid_in = 1'b0;
      if (k == drop_at) repeat_in = 1'b0;
      e_env = (k < len) ? exp_env[k] : 1'b0;
      e_ir  = (k < len) ? exp_ir[k] : 1'b0;
      e_rdy = (k == len);
      if (k < len) cap_env.push_back(envelope_out);
      if (envelope_out !== e_env) begin
        if (bad_env == 0) first_env = k;
        bad_env++;
      end
      if (ir_out !== e_ir) begin
        if (bad_ir == 0) first_ir = k;
        bad_ir++;
      end
      if ((ready_out !== e_rdy) || (busy_out !== !e_rdy)) begin
        if (bad_rdy == 0) first_rdy = k;
        bad_rdy++;
      end
    end
  endtask

  task automatic test_reset();
    rst_in = 1'b1; valid_in = 1'b0; repeat_in = 1'b0; code_in = '0;
    repeat (3) @(negedge clk_in);
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b want 1", ready_out); end
    checks++;
    if (busy_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b want 0", busy_out); end
    checks++;
    if (envelope_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_env: got %b want 0", envelope_out); end
    checks++;
    if (ir_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_ir: got %b want 0", ir_out); end
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic test_fixed_codes();
    logic [31:0] codes[3];
    logic [31:0] got;
    codes[0] = 32'h0000_0000;
    codes[1] = 32'hFFFF_FFFF;
    codes[2] = 32'h8000_0001;
    for (int i = 0; i < 3; i++) begin
      build_frame(codes[i], 0);
      drive_frame(codes[i], -10, -10);
      checks++;
      if (bad_env !== 0) begin errors++; $display("[TB] FAIL fixed_env %h: %0d bad cycles from %0d, want 0", codes[i], bad_env, first_env); end
      checks++;
      if (bad_ir !== 0) begin errors++; $display("[TB] FAIL fixed_ir %h: %0d bad cycles from %0d, want 0", codes[i], bad_ir, first_ir); end
      checks++;
      if (bad_rdy !== 0) begin errors++; $display("[TB] FAIL fixed_ready %h: %0d bad cycles from %0d, want 0", codes[i], bad_rdy, first_rdy); end
      got = decode_env();
      checks++;
      if (got !== codes[i]) begin errors++; $display("[TB] FAIL fixed_decode: got %h want %h", got, codes[i]); end
    end
  endtask

  task automatic test_random();
    logic [31:0] code;
    logic [31:0] got;
    for (int i = 0; i < 3; i++) begin
      code = $urandom;
      build_frame(code, 0);
      drive_frame(code, -10, -10);
      checks++;
      if (bad_env !== 0) begin errors++; $display("[TB] FAIL rand_env %h: %0d bad cycles from %0d, want 0", code, bad_env, first_env); end
      checks++;
      if (bad_ir !== 0) begin errors++; $display("[TB] FAIL rand_ir %h: %0d bad cycles from %0d, want 0", code, bad_ir, first_ir); end
      checks++;
      if (bad_rdy !== 0) begin errors++; $display("[TB] FAIL rand_ready %h: %0d bad cycles from %0d, want 0", code, bad_rdy, first_rdy); end
      got = decode_env();
      checks++;
      if (got !== code) begin errors++; $display("[TB] FAIL rand_decode: got %h want %h", got, code); end
    end
  endtask

  task automatic test_ignored_valid();
    logic [31:0] code;
    logic [31:0] got;
    int stray;
    code = $urandom;
    build_frame(code, 0);
    drive_frame(code, 500, -10);
    checks++;
    if (bad_env !== 0) begin errors++; $display("[TB] FAIL busy_valid_env: %0d bad cycles from %0d, want 0", bad_env, first_env); end
    checks++;
    if (bad_rdy !== 0) begin errors++; $display("[TB] FAIL busy_valid_ready: %0d bad cycles from %0d, want 0", bad_rdy, first_rdy); end
    got = decode_env();
    checks++;
    if (got !== code) begin errors++; $display("[TB] FAIL busy_valid_decode: got %h want %h", got, code); end
    stray = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk_in);
      if ((envelope_out !== 1'b0) || (ready_out !== 1'b1)) stray++;
    end
    checks++;
    if (stray !== 0) begin errors++; $display("[TB] FAIL no_second_frame: %0d active cycles, want 0", stray); end
  endtask

  task automatic test_reset_mid_frame();
    logic [31:0] code;
    logic [31:0] got;
    code = 32'hB00F_0001;
    // Abort in the first bit space (bit 31 = 1, cycles 250..279)
    @(negedge clk_in);
    code_in = code; valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in = 1'b0;
    repeat (254) @(negedge clk_in);
    #1 rst_in = 1'b1;
    #1;
    checks++;
    if (ready_out !== 1'b1) begin errors++; $display("[TB] FAIL space_rst_ready: got %b want 1", ready_out); end
    checks++;
    if ((envelope_out !== 1'b0) || (ir_out !== 1'b0) || (busy_out !== 1'b0)) begin
      errors++; $display("[TB] FAIL space_rst_outs: env %b ir %b busy %b, want 0 0 0", envelope_out, ir_out, busy_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    // Abort inside the lead mark while the carrier is high (cycle 48)
    @(negedge clk_in);
    code_in = code; valid_in = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    valid_in = 1'b0;
    repeat (48) @(negedge clk_in);
    checks++;
    if ((envelope_out !== 1'b1) || (ir_out !== 1'b1)) begin
      errors++; $display("[TB] FAIL pre_rst_mark: env %b ir %b, want 1 1", envelope_out, ir_out);
    end
    #1 rst_in = 1'b1;
    #1;
    checks++;
    if ((envelope_out !== 1'b0) || (ir_out !== 1'b0) || (ready_out !== 1'b1)) begin
      errors++; $display("[TB] FAIL mark_rst_outs: env %b ir %b ready %b, want 0 0 1", envelope_out, ir_out, ready_out);
    end
    @(negedge clk_in);
    rst_in = 1'b0;
    // Full frame after the abort
    code = $urandom;
    build_frame(code, 0);
    drive_frame(code, -10, -10);
    checks++;
    if (bad_env !== 0) begin errors++; $display("[TB] FAIL post_rst_env: %0d bad cycles from %0d, want 0", bad_env, first_env); end
    checks++;
    if (bad_ir !== 0) begin errors++; $display("[TB] FAIL post_rst_ir: %0d bad cycles from %0d, want 0", bad_ir, first_ir); end
    checks++;
    if (bad_rdy !== 0) begin errors++; $display("[TB] FAIL post_rst_ready: %0d bad cycles from %0d, want 0", bad_rdy, first_rdy); end
    got = decode_env();
    checks++;
    if (got !== code) begin errors++; $display("[TB] FAIL post_rst_decode: got %h want %h", got, code); end
  endtask

  task automatic test_repeat();
    logic [31:0] code;
    int nrep;
    int base;
    int drop;
    code = 32'hA5A5_A5A5;
`ifdef IR_TX_REPEAT_EN
    nrep = 2;
`else
    nrep = 0;
`endif
    build_frame(code, nrep);
    base = exp_env.size() - nrep * (21 + GAP) * U;
    drop = (nrep > 0) ? base + (nrep - 1) * (21 + GAP) * U + 100 : exp_env.size();
    repeat_in = 1'b1;
    drive_frame(code, -10, drop);
    repeat_in = 1'b0;
    checks++;
    if (bad_env !== 0) begin errors++; $display("[TB] FAIL repeat_env: %0d bad cycles from %0d, want 0", bad_env, first_env); end
    checks++;
    if (bad_ir !== 0) begin errors++; $display("[TB] FAIL repeat_ir: %0d bad cycles from %0d, want 0", bad_ir, first_ir); end
    checks++;
    if (bad_rdy !== 0) begin errors++; $display("[TB] FAIL repeat_ready: %0d bad cycles from %0d, want 0", bad_rdy, first_rdy); end
  endtask

  // Scenario sequence
  initial begin
    test_reset();
    test_fixed_codes();
    test_random();
    test_ignored_valid();
    test_reset_mid_frame();
    test_repeat();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
